uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx transmitter between NREQ byte requesters (e.g. score/paddle reporters of the game).
//  Grants round-robin, launches one frame per grant via tx_start/tx_din, and waits for tx_done_tick.
//  Inserts a programmable idle gap between frames. Sits between the game logic and uart_tx.
// PARAMETERS
//  NREQ        2      number of requesters, 2..8
//  GAP_CYC     16     clk cycles in GAP after each frame, >=1
//  TIMEOUT_CYC 200000 clk cycles in WAIT before abort (used only with UART_ARB_TIMEOUT_EN)
// PORTS
//  clk       in   1       system clock, rising edge
//  reset     in   1       asynchronous, active-high reset
//  req       in   NREQ    level request per requester; held with data until gnt
//  req_data  in   8*NREQ  byte of requester i on [8*i+7:8*i]
//  gnt       out  NREQ    one-hot, 1-cycle pulse: byte of that requester accepted
//  done      out  NREQ    one-hot, 1-cycle pulse: that requester's frame fully sent
//  err       out  1       1-cycle pulse: frame aborted on timeout (0 without macro)
//  busy      out  1       high in WAIT or GAP
//  tx_start  out  1       to uart_tx; 1-cycle launch pulse
//  tx_din    out  8       to uart_tx; byte, stable from tx_start until tx_done_tick
//  tx_done   in   1       from uart_tx tx_done_tick (1-cycle pulse)
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, ptr=0, owner=0, gnt=0, done=0, err=0, busy=0,
//    tx_start=0, tx_din=8'h00, gap counter=0, timeout counter=0.
//  - States: IDLE, WAIT, GAP.
//  - IDLE: if |req, winner = first i with req[i]=1, searching ptr, ptr+1, ... mod NREQ.
//    Same edge: owner<=winner, tx_din<=req_data[winner], gnt[winner]<=1, tx_start<=1, ->WAIT.
//    Latency: req sampled at edge k -> gnt/tx_start high cycle k+1, exactly one cycle.
//  - WAIT: tx_start=0, tx_din held. On tx_done=1: done[owner]<=1, ptr<=(owner+1) mod NREQ,
//    gap counter<=0, ->GAP.
//  - GAP: counter increments each clk; at count GAP_CYC-1 ->IDLE. req ignored in GAP.
//  - Minimum spacing: tx_done edge to next tx_start >= GAP_CYC+1 cycles.
//  - tx_done in IDLE or GAP is ignored; no output reacts.
//  - req dropped before its gnt: not served, no gnt/done. req held after gnt: re-arbitrated in the
//    next IDLE as a new byte, lower priority than any other active requester.
//  - All req high: grants rotate 0,1,..,NREQ-1,0; no requester waits more than NREQ-1 frames.
//  - ptr arithmetic wraps at NREQ (not a power of 2 in general); widths $clog2(NREQ), min 1.
//  - Reset mid-frame: immediate return to reset values; the frame in uart_tx is not tracked.
// CONFIGURATION
//  UART_ARB_TIMEOUT_EN defined: WAIT counter cleared on entry, +1 per clk; at TIMEOUT_CYC-1 with
//    no tx_done: err<=1, no done pulse, ptr<=(owner+1) mod NREQ, ->GAP. tx_done on the expiry
//    cycle wins (normal completion, no err).
//  Not defined: no counter logic; WAIT only exits on tx_done or reset; err tied 0.
// TESTING
//  1. Reset, req=2'b01, data0=8'hA5 -> gnt=01 and tx_start 1 cycle later, tx_din=A5; tx_done -> done=01.
//  2. req=2'b11 held, data0=11, data1=22 -> tx_din sequence 11,22,11,22; gnt alternates 01,10.
//  3. tx_done at cycle D -> tx_start not before D+GAP_CYC+1; tx_done pulses in IDLE/GAP -> no output.
//  4. Assert reset 3 cycles into WAIT -> all outputs at reset values next cycle; ptr=0.
//  5. TIMEOUT_EN, TIMEOUT_CYC=50, no tx_done -> err pulse 50 cycles after tx_start, no done, next grant rotates.
//  6. NREQ=3, req=3'b101 after grant to 0 -> next grant 2, then 0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter signal bundle for uart_tx_arbiter.
// master = arbiter side, slave = game logic + uart_tx side.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              err;
  logic              busy;
  logic              tx_start;
  logic [7:0]        tx_din;
  logic              tx_done;

  modport master (
    input  req, req_data, tx_done,
    output gnt, done, err, busy, tx_start, tx_din
  );

  modport slave (
    output req, req_data, tx_done,
    input  gnt, done, err, busy, tx_start, tx_din
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NREQ byte requesters, with idle gap between frames.
// Define UART_ARB_TIMEOUT_EN to abort a frame (err pulse) when tx_done never arrives.
module uart_tx_arbiter #(
  parameter int NREQ        = 2,
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 200000
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.master bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = $clog2(GAP_CYC + 1);

  if (NREQ < 2 || NREQ > 8 || GAP_CYC < 1 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, owner_q, owner_d, owner_inc, winner;
  logic            found;
  logic [GW-1:0]   gap_q, gap_d;
  logic            gap_end, grant, frame_ok, to_expire;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic            busy_q, busy_d, tx_start_q, tx_start_d;
  logic [7:0]      tx_din_q, tx_din_d;
  int unsigned     idx;

  // Rotating-priority search starting at ptr; wraps at NREQ, not at 2**PW.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - 32'(NREQ);
      if (!found && bus.req[PW'(idx)]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  assign owner_inc = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
  assign gap_end   = (state_q == GAP) && (gap_q == GW'(GAP_CYC - 1));
  assign grant     = (state_q == IDLE) && found;
  assign frame_ok  = (state_q == WAIT) && bus.tx_done;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_q;
  logic          err_q;

  // tx_done on the expiry cycle takes precedence over the abort.
  assign to_expire = (state_q == WAIT) && !bus.tx_done && (to_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= (state_q == WAIT) ? to_q + 1'b1 : '0;
      err_q <= to_expire;
    end
  end

  assign bus.err = err_q;
`else
  assign to_expire = 1'b0;
  assign bus.err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found) state_d = WAIT;
      WAIT:    if (frame_ok || to_expire) state_d = GAP;
      GAP:     if (gap_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d      = grant ? (NREQ'(1) << winner) : '0;
    done_d     = frame_ok ? (NREQ'(1) << owner_q) : '0;
    tx_start_d = grant;
    tx_din_d   = grant ? bus.req_data[32'(winner) * 8 +: 8] : tx_din_q;
    owner_d    = grant ? winner : owner_q;
    ptr_d      = (frame_ok || to_expire) ? owner_inc : ptr_q;
    gap_d      = (state_q == GAP) ? gap_q + 1'b1 : '0;
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      owner_q    <= '0;
      gap_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_din_q   <= 8'h00;
    end else begin
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      gap_q      <= gap_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      tx_start_q <= tx_start_d;
      tx_din_q   <= tx_din_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_din   = tx_din_q;

endmodule
